// File: rtl/des_block_ingress.sv
// DES ingress: assembles 8-byte blocks from a byte stream, applies the initial
// permutation and holds one permuted block for the round engine.
module des_block_ingress #(
  parameter int MSB_FIRST  = 1,
  parameter int ERR_STICKY = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data_i,
  input  logic        in_valid_i,
  input  logic        in_last_i,
  output logic        in_ready_o,
  input  logic        flush_i,
  output logic [63:0] ip_block_o,
  output logic        ip_valid_o,
  input  logic        ip_ready_i,
  output logic        frame_err_o,
  output logic [2:0]  byte_cnt_o
);

  typedef enum logic {COLLECT = 1'b0, STALL = 1'b1} state_t;

  // Source DES bit for each output DES bit, output bit 1 first.
  localparam int IP_TAB [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,
    60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,
    64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,
    59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,
    63, 55, 47, 39, 31, 23, 15, 7
  };

  function automatic logic [63:0] ip_perm(input logic [63:0] d);
    logic [63:0] r;
    logic [5:0]  src;
    r = '0;
    for (int k = 0; k < 64; k++) begin
      src = 6'(64 - IP_TAB[k]);
      r[6'(63 - k)] = d[src];
    end
    return r;
  endfunction

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_up;
  logic [63:0] r_sr;
  logic [2:0]  r_cnt;
  logic [63:0] r_block;
  logic        r_vld;
  logic        r_err;

  logic        w_in_xfer;
  logic        w_out_xfer;
  logic        w_done;
  logic        w_abort;
  logic        w_err;
  logic        w_err_nxt;
  logic [63:0] w_sr_shift;
  logic [63:0] w_sr_nxt;
  logic [2:0]  w_cnt_nxt;
  logic        w_vld_nxt;

  // Ready comes from registered state only, so the last byte waits for a drain.
  assign in_ready_o  = r_up && (r_state == COLLECT);
  assign ip_block_o  = r_block;
  assign ip_valid_o  = r_vld;
  assign frame_err_o = r_err;
  assign byte_cnt_o  = r_cnt;

  always_comb begin
    w_in_xfer   = in_valid_i && in_ready_o && !flush_i;
    w_out_xfer  = r_vld && ip_ready_i;
    w_sr_shift  = (MSB_FIRST != 0) ? {r_sr[55:0], in_data_i} : {in_data_i, r_sr[63:8]};
    w_done      = w_in_xfer && (r_cnt == 3'd7);
    w_abort     = w_in_xfer && (r_cnt != 3'd7) && in_last_i;
    w_err       = w_abort || (w_done && !in_last_i);
    w_err_nxt   = (ERR_STICKY != 0) ? (r_err || w_err) : w_err;
    w_cnt_nxt   = r_cnt;
    w_sr_nxt    = r_sr;
    w_vld_nxt   = r_vld;
    if (flush_i) begin
      w_cnt_nxt = 3'd0;
      w_sr_nxt  = '0;
      w_vld_nxt = 1'b0;
    end else begin
      if (w_out_xfer) w_vld_nxt = 1'b0;
      if (w_abort) begin
        w_cnt_nxt = 3'd0;
        w_sr_nxt  = '0;
      end else if (w_done) begin
        w_cnt_nxt = 3'd0;
        w_sr_nxt  = '0;
        w_vld_nxt = 1'b1;
      end else if (w_in_xfer) begin
        w_cnt_nxt = r_cnt + 3'd1;
        w_sr_nxt  = w_sr_shift;
      end
    end
    w_state_nxt = ((w_cnt_nxt == 3'd7) && w_vld_nxt) ? STALL : COLLECT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= COLLECT;
      r_up    <= 1'b0;
      r_sr    <= '0;
      r_cnt   <= 3'd0;
      r_block <= '0;
      r_vld   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_up    <= 1'b1;
      r_sr    <= w_sr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_vld   <= w_vld_nxt;
      r_err   <= w_err_nxt;
      if (w_done) r_block <= ip_perm(w_sr_shift);
    end
  end

endmodule

// File: tb/tb_des_block_ingress.sv
// Directed bench for des_block_ingress: vector table plus hand-written
// stall, framing, flush and reset sequences on an MSB-first/pulse instance
// and an LSB-first/sticky instance sharing the same stimulus.
module tb_des_block_ingress;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        flush;
  logic        ip_ready;

  logic        rdy0, vld0, err0;
  logic [63:0] blk0;
  logic [2:0]  cnt0;
  logic        rdy1, vld1, err1;
  logic [63:0] blk1;
  logic [2:0]  cnt1;

  int checks   = 0;
  int failures = 0;

  // Final permutation (inverse of IP): input DES bit j lands at output DES bit FP[j-1].
  int FP [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,
    39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,
    37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,
    35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,
    33, 1, 41,  9, 49, 17, 57, 25
  };

  typedef struct {
    logic [63:0] blk;
    logic [63:0] exp;
    logic        good_last;
    logic        exp_err;
  } vec_t;

  des_block_ingress #(.MSB_FIRST(1), .ERR_STICKY(0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_data_i(in_data), .in_valid_i(in_valid),
    .in_last_i(in_last), .in_ready_o(rdy0), .flush_i(flush),
    .ip_block_o(blk0), .ip_valid_o(vld0), .ip_ready_i(ip_ready),
    .frame_err_o(err0), .byte_cnt_o(cnt0));

  des_block_ingress #(.MSB_FIRST(0), .ERR_STICKY(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_data_i(in_data), .in_valid_i(in_valid),
    .in_last_i(in_last), .in_ready_o(rdy1), .flush_i(flush),
    .ip_block_o(blk1), .ip_valid_o(vld1), .ip_ready_i(ip_ready),
    .frame_err_o(err1), .byte_cnt_o(cnt1));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Called just after a negedge; returns just after the negedge following acceptance.
  task automatic push(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    while (!rdy0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("push_timeout", 64'(rdy0), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_block(input logic [63:0] b, input logic good_last);
    logic [63:0] t;
    t = b;
    for (int i = 0; i < 8; i++) begin
      push(t[63:56], (i == 7) ? good_last : 1'b0);
      t = t << 8;
    end
  endtask

  // A completed output transfer must clear valid unless a block completed on the same edge.
  logic mon_x, mon_c, mon_arm;
  always @(posedge clk) begin
    mon_x   = rst_n && vld0 && ip_ready && !flush;
    mon_c   = rst_n && in_valid && rdy0 && (cnt0 == 3'd7) && !flush;
    mon_arm = 1'b1;
  end
  always @(negedge clk) begin
    if (mon_arm && rst_n) begin
      if (mon_c) chk("no_complete_while_held", 64'(mon_x), 64'd0);
      else if (mon_x) chk("valid_clears_after_xfer", 64'(vld0), 64'd0);
    end
    mon_arm = 1'b0;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs [5];
    logic [63:0] uni;
    logic [63:0] inb;
    int          i0, ip1, j1;

    mon_arm = 1'b0;
    rst_n = 1'b0; in_data = 8'h00; in_valid = 1'b0; in_last = 1'b0;
    flush = 1'b0; ip_ready = 1'b1;

    vecs[0] = '{64'h0123456789ABCDEF, 64'hCC00CCFFF0AAF0AA, 1'b1, 1'b0};
    vecs[1] = '{64'h0000000000000000, 64'h0000000000000000, 1'b1, 1'b0};
    vecs[2] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b1, 1'b0};
    vecs[3] = '{64'h8000000000000000, 64'h0000000001000000, 1'b1, 1'b0};
    vecs[4] = '{64'h0123456789ABCDEF, 64'hCC00CCFFF0AAF0AA, 1'b0, 1'b1};

    repeat (2) @(negedge clk);
    chk("rst_block", blk0, 64'd0);
    chk("rst_valid", 64'(vld0), 64'd0);
    chk("rst_err", 64'(err0), 64'd0);
    chk("rst_cnt", 64'(cnt0), 64'd0);
    chk("rst_ready", 64'(rdy0), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_release", 64'(rdy0), 64'd1);

    // Vector table
    for (int v = 0; v < 5; v++) begin
      send_block(vecs[v].blk, vecs[v].good_last);
      chk($sformatf("vec%0d_valid", v), 64'(vld0), 64'd1);
      chk($sformatf("vec%0d_block", v), blk0, vecs[v].exp);
      chk($sformatf("vec%0d_err", v), 64'(err0), 64'(vecs[v].exp_err));
      @(negedge clk);
      chk($sformatf("vec%0d_drained", v), 64'(vld0), 64'd0);
      chk($sformatf("vec%0d_err_pulse_end", v), 64'(err0), 64'd0);
    end
    chk("sticky_err_after_bad_last", 64'(err1), 64'd1);

    // Single-bit walk on both byte orders
    uni = '0;
    for (int j = 1; j <= 64; j++) begin
      inb = 64'd1 << (64 - j);
      send_block(inb, 1'b1);
      chk($sformatf("walk%0d_msb", j), blk0, 64'd1 << (64 - FP[j-1]));
      i0  = 64 - j;
      ip1 = (7 - i0 / 8) * 8 + (i0 % 8);
      j1  = 64 - ip1;
      chk($sformatf("walk%0d_lsb", j), blk1, 64'd1 << (64 - FP[j1-1]));
      uni = uni | blk0;
    end
    chk("walk_union", uni, 64'hFFFFFFFFFFFFFFFF);
    @(negedge clk);

    // Backpressure: block A held while block B stalls on its last byte
    ip_ready = 1'b0;
    send_block(64'h0123456789ABCDEF, 1'b1);
    for (int i = 0; i < 7; i++) push(8'hFF, 1'b0);
    chk("stall_cnt", 64'(cnt0), 64'd7);
    chk("stall_ready", 64'(rdy0), 64'd0);
    @(negedge clk);
    chk("stall_hold_block", blk0, 64'hCC00CCFFF0AAF0AA);
    chk("stall_hold_valid", 64'(vld0), 64'd1);
    in_data = 8'hFF; in_last = 1'b1; in_valid = 1'b1; ip_ready = 1'b1;
    @(negedge clk);
    chk("drain_valid_low", 64'(vld0), 64'd0);
    chk("drain_ready_up", 64'(rdy0), 64'd1);
    chk("drain_cnt", 64'(cnt0), 64'd7);
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    chk("blk2_valid", 64'(vld0), 64'd1);
    chk("blk2_block", blk0, 64'hFFFFFFFFFFFFFFFF);
    chk("blk2_cnt", 64'(cnt0), 64'd0);
    @(negedge clk);

    // Early in_last on byte 3
    for (int i = 0; i < 3; i++) push(8'h5A, 1'b0);
    push(8'h5A, 1'b1);
    chk("early_last_err", 64'(err0), 64'd1);
    chk("early_last_cnt", 64'(cnt0), 64'd0);
    chk("early_last_novalid", 64'(vld0), 64'd0);
    @(negedge clk);
    chk("early_last_pulse_end", 64'(err0), 64'd0);
    chk("early_last_sticky", 64'(err1), 64'd1);
    send_block(64'h0, 1'b1);
    chk("after_err_valid", 64'(vld0), 64'd1);
    chk("after_err_block", blk0, 64'h0);
    @(negedge clk);

    // Flush with partial block, held block and a coincident byte
    ip_ready = 1'b0;
    send_block(64'h0123456789ABCDEF, 1'b1);
    for (int i = 0; i < 5; i++) push(8'hFF, 1'b0);
    chk("pre_flush_cnt", 64'(cnt0), 64'd5);
    chk("pre_flush_valid", 64'(vld0), 64'd1);
    in_data = 8'h77; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush_cnt", 64'(cnt0), 64'd0);
    chk("flush_valid", 64'(vld0), 64'd0);
    chk("flush_keeps_sticky", 64'(err1), 64'd1);
    ip_ready = 1'b1;
    send_block(64'h0123456789ABCDEF, 1'b1);
    chk("post_flush_block", blk0, 64'hCC00CCFFF0AAF0AA);
    @(negedge clk);

    // Asynchronous reset mid-block
    for (int i = 0; i < 3; i++) push(8'h11, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_block", blk0, 64'd0);
    chk("async_rst_cnt", 64'(cnt0), 64'd0);
    chk("async_rst_ready", 64'(rdy0), 64'd0);
    chk("async_rst_sticky_clear", 64'(err1), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("release_ready_low", 64'(rdy0), 64'd0);
    @(negedge clk);
    send_block(64'hFFFFFFFFFFFFFFFF, 1'b1);
    chk("post_rst_valid", 64'(vld0), 64'd1);
    chk("post_rst_block", blk0, 64'hFFFFFFFFFFFFFFFF);
    chk("post_rst_err", 64'(err0), 64'd0);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/des_block_ingress.md
Name: des_block_ingress

Overview:
- Front end of the DES datapath: the input-side counterpart of the output permutation stage.
- Accepts plaintext/ciphertext as a byte stream with valid/ready handshake, assembles 64-bit blocks, applies the DES initial permutation (IP), and presents the permuted block to the round engine over a valid/ready interface.
- Includes a one-block output holding register and framing checks on the `in_last` marker.

Parameters:
- MSB_FIRST, 1, 1: first byte of a block lands in bits [63:56]; 0: first byte lands in bits [7:0].
- ERR_STICKY, 0, 1: `frame_err_o` stays high until reset; 0: `frame_err_o` is a one-cycle pulse.

Ports:
- clk  input  1  block clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data_i  input  8  byte of the input block.
- in_valid_i  input  1  `in_data_i` is valid.
- in_last_i  input  1  marks the 8th (final) byte of a block.
- in_ready_o  output  1  block accepts a byte this cycle.
- flush_i  input  1  synchronous abort; discards the partial block and the held block.
- ip_block_o  output  64  IP-permuted block (bit 63 = DES bit 1).
- ip_valid_o  output  1  `ip_block_o` is valid.
- ip_ready_i  input  1  downstream accepts `ip_block_o`.
- frame_err_o  output  1  framing error indication.
- byte_cnt_o  output  3  bytes collected of the current block (debug).

Behaviour:
- Reset (async assert, sync release): all outputs 0 at reset, i.e. `ip_block_o`=0, `ip_valid_o`=0, `frame_err_o`=0, `byte_cnt_o`=0 and `in_ready_o`=0. Internally, the shift register=0 and state=COLLECT. `in_ready_o` rises on the first clock after reset release.
- Byte transfer: occurs when `in_valid_i` && `in_ready_o`. Counter increments 0..7; on the 8th byte it wraps to 0.
- `in_ready_o` = !(`byte_cnt_o`==7 && `ip_valid_o`). It depends on registered state only, with no combinational path from `ip_ready_i`. Result: the last byte stalls while the held block is undrained.
- Block completion: on acceptance of byte 7 the assembled 64 bits pass through IP and are registered into `ip_block_o`. `ip_valid_o` rises the next cycle. Latency from last byte to valid is 1 cycle.
- Throughput: with `ip_ready_i` held high, bytes are accepted on every cycle, giving one block per 8 cycles.
- Output handshake: `ip_block_o` is stable while `ip_valid_o` && !`ip_ready_i`. `ip_valid_o` clears the cycle after the transfer, unless a new block completes in the same cycle as the transfer. That case is impossible by the stall rule, but the bench must check it never happens.
- IP mapping: DES numbering, bit n maps to index 64-n. Output bits in order, DES bit 1 first, take input DES bits 58 50 42 34 26 18 10 2, 60 52 44 36 28 20 12 4, 62 54 46 38 30 22 14 6, 64 56 48 40 32 24 16 8, 57 49 41 33 25 17 9 1, 59 51 43 35 27 19 11 3, 61 53 45 37 29 21 13 5, 63 55 47 39 31 23 15 7. This is the exact inverse of the final permutation; all 64 sources are distinct.
- Framing: `in_last_i` must be 1 exactly on byte 7.
  - `in_last_i`=1 on bytes 0..6: partial block discarded, counter to 0, `frame_err_o` asserted, no `ip_valid_o`.
  - `in_last_i`=0 on byte 7: the block is still delivered and `frame_err_o` is asserted.
  - `in_last_i` is ignored when no transfer occurs.
- States: COLLECT (counter < 7, or output free) and STALL (counter==7 && `ip_valid_o`). STALL→COLLECT on output drain.
- Flush: the same cycle counter goes to 0, `ip_valid_o` to 0 and the shift register to 0. Flush overrides a simultaneous input transfer (byte dropped) and a simultaneous output transfer (treated as accepted). `frame_err_o` is not cleared in sticky mode.
- Reset mid-block: the partial block is lost, with no error flagged.

Test Plan:
- MSB_FIRST=1, bytes 01 23 45 67 89 AB CD EF (last on EF), `ip_ready_i`=1 → one cycle later `ip_valid_o`=1, `ip_block_o`=64'hCC00CCFFF0AAF0AA, `frame_err_o`=0.
- Single-bit walk: 64 blocks each with one input bit set → exactly one output bit set, matching the IP table; the union of outputs covers all 64 bits.
- `ip_ready_i`=0 after block 1, stream block 2 → `in_ready_o` drops with `byte_cnt_o`=7 and `ip_block_o` holds. Raise `ip_ready_i` → block 1 is taken, byte 7 is accepted next cycle, and block 2 is valid one cycle later.
- `in_last_i` on byte 3 → `frame_err_o` pulse (ERR_STICKY=0), no `ip_valid_o`, `byte_cnt_o`=0. A following correct block of all 00 outputs 64'h0.
- `flush_i` asserted with `byte_cnt_o`=5 and a held block, coinciding with `in_valid_i` → next cycle `byte_cnt_o`=0, `ip_valid_o`=0, and the byte is dropped.
- `rst_n` low asynchronously mid-block (between clock edges) → outputs 0 immediately. After release, block FF×8 outputs 64'hFFFFFFFFFFFFFFFF.
